// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: ID-stage operand forwarding with load-use / pending-result
// stall detection and a long-latency-unit register scoreboard.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_rs_addr_i [NRD*5]     ID source register addresses (port p at [p*5+:5])
//   rf_raddr_o   [NRD*5]     pass-through of id_rs_addr_i to the register file
//   rf_rdata_i   [NRD*XLEN]  register file read data
//   ex_/mem_/wb_rd_*         destination address / write enable / data per stage
//   ex_is_load_i             EX instruction is a load (data not yet available)
//   mem_data_ok_i            MEM result valid
//   lu_issue_i/lu_issue_rd_i long-latency op accepted, writing rd
//   lu_done_i/lu_done_rd_i   long-latency result on the WB port this cycle
//   lu_kill_i                cancel every outstanding long-latency op
//   rs_data_o    [NRD*XLEN]  forwarded operands (don't-care while stall_o=1)
//   stall_o                  ID must hold (combinational)
//   stall_cnt_o  [CNT_W]     saturating stall-cycle count
//   hang_o                   sticky: stall held HANG_LIMIT consecutive cycles

// Per-read-port forwarding mux and stall decision.
module fwd_port #(
  parameter int XLEN = 64
) (
  input  logic [4:0]      rs_addr_i,
  input  logic [XLEN-1:0] rf_rdata_i,
  input  logic [4:0]      ex_rd_addr_i,
  input  logic            ex_rd_wen_i,
  input  logic [XLEN-1:0] ex_rd_data_i,
  input  logic            ex_is_load_i,
  input  logic [4:0]      mem_rd_addr_i,
  input  logic            mem_rd_wen_i,
  input  logic [XLEN-1:0] mem_rd_data_i,
  input  logic            mem_data_ok_i,
  input  logic [4:0]      wb_rd_addr_i,
  input  logic            wb_rd_wen_i,
  input  logic [XLEN-1:0] wb_rd_data_i,
  input  logic [31:0]     busy_i,
  input  logic            lu_done_i,
  input  logic [4:0]      lu_done_rd_i,
  output logic [XLEN-1:0] rs_data_o,
  output logic            stall_o
);
  logic nz, ex_hit, mem_hit, wb_hit, busy_src, done_hit;

  always_comb begin
    nz       = (rs_addr_i != 5'd0);
    ex_hit   = nz && ex_rd_wen_i  && (ex_rd_addr_i  == rs_addr_i);
    mem_hit  = nz && mem_rd_wen_i && (mem_rd_addr_i == rs_addr_i);
    wb_hit   = nz && wb_rd_wen_i  && (wb_rd_addr_i  == rs_addr_i);
    busy_src = nz && busy_i[rs_addr_i];
    // A pending result retiring this very cycle is taken straight off WB.
    done_hit = busy_src && lu_done_i && (lu_done_rd_i == rs_addr_i);

    rs_data_o = rf_rdata_i;
    stall_o   = 1'b0;
    if (!nz) begin
      rs_data_o = '0;
    end else if (ex_hit) begin
      // A load in EX shadows older stages: MEM is not consulted.
      rs_data_o = ex_rd_data_i;
      stall_o   = ex_is_load_i;
    end else if (mem_hit) begin
      rs_data_o = mem_rd_data_i;
      stall_o   = !mem_data_ok_i;
    end else if (done_hit) begin
      rs_data_o = wb_rd_data_i;
    end else if (busy_src) begin
      // Outstanding long-latency write: any WB hit is stale.
      stall_o   = 1'b1;
    end else if (wb_hit) begin
      rs_data_o = wb_rd_data_i;
    end
  end
endmodule

module fwd_scoreboard #(
  parameter int XLEN       = 64,
  parameter int NRD        = 2,
  parameter int HANG_LIMIT = 1024,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*5-1:0]    id_rs_addr_i,
  output logic [NRD*5-1:0]    rf_raddr_o,
  input  logic [NRD*XLEN-1:0] rf_rdata_i,
  input  logic [4:0]          ex_rd_addr_i,
  input  logic                ex_rd_wen_i,
  input  logic [XLEN-1:0]     ex_rd_data_i,
  input  logic                ex_is_load_i,
  input  logic [4:0]          mem_rd_addr_i,
  input  logic                mem_rd_wen_i,
  input  logic [XLEN-1:0]     mem_rd_data_i,
  input  logic                mem_data_ok_i,
  input  logic [4:0]          wb_rd_addr_i,
  input  logic                wb_rd_wen_i,
  input  logic [XLEN-1:0]     wb_rd_data_i,
  input  logic                lu_issue_i,
  input  logic [4:0]          lu_issue_rd_i,
  input  logic                lu_done_i,
  input  logic [4:0]          lu_done_rd_i,
  input  logic                lu_kill_i,
  output logic [NRD*XLEN-1:0] rs_data_o,
  output logic                stall_o,
  output logic [CNT_W-1:0]    stall_cnt_o,
  output logic                hang_o
);
  localparam int RUN_W = $clog2(HANG_LIMIT);
  localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(HANG_LIMIT - 1);

  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             hang_q, hang_d;
  logic [NRD-1:0]   stall_p;

  assign rf_raddr_o = id_rs_addr_i;

  for (genvar p = 0; p < NRD; p++) begin : g_port
    fwd_port #(.XLEN(XLEN)) u_port (
      .rs_addr_i     (id_rs_addr_i[p*5+:5]),
      .rf_rdata_i    (rf_rdata_i[p*XLEN+:XLEN]),
      .ex_rd_addr_i  (ex_rd_addr_i),
      .ex_rd_wen_i   (ex_rd_wen_i),
      .ex_rd_data_i  (ex_rd_data_i),
      .ex_is_load_i  (ex_is_load_i),
      .mem_rd_addr_i (mem_rd_addr_i),
      .mem_rd_wen_i  (mem_rd_wen_i),
      .mem_rd_data_i (mem_rd_data_i),
      .mem_data_ok_i (mem_data_ok_i),
      .wb_rd_addr_i  (wb_rd_addr_i),
      .wb_rd_wen_i   (wb_rd_wen_i),
      .wb_rd_data_i  (wb_rd_data_i),
      .busy_i        (busy_q),
      .lu_done_i     (lu_done_i),
      .lu_done_rd_i  (lu_done_rd_i),
      .rs_data_o     (rs_data_o[p*XLEN+:XLEN]),
      .stall_o       (stall_p[p])
    );
  end

  assign stall_o     = |stall_p;
  assign stall_cnt_o = stall_cnt_q;
  assign hang_o      = hang_q;

  always_comb begin
    busy_d = busy_q;
    if (lu_kill_i) begin
      busy_d = '0;
    end else begin
      // Clear before set so a same-register issue re-claims the entry.
      if (lu_done_i)  busy_d[lu_done_rd_i]  = 1'b0;
      if (lu_issue_i) busy_d[lu_issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;

    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;

    // Run counter parks at the limit; hang is sticky so it never needs to wrap.
    run_d = '0;
    if (stall_o) run_d = (run_q == RUN_LIM) ? run_q : run_q + 1'b1;

    hang_d = hang_q | (stall_o && (run_q == RUN_LIM));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      stall_cnt_q <= '0;
      run_q       <= '0;
      hang_q      <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
      run_q       <= run_d;
      hang_q      <= hang_d;
    end
  end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios followed by
// randomized traffic, checked against an architectural model of the rules.
module tb_fwd_scoreboard;
  localparam int XLEN = 64;
  localparam int NRD  = 2;
  localparam int HL   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [NRD*5-1:0]    id_rs_addr;
  logic [NRD*5-1:0]    rf_raddr_o;
  logic [NRD*XLEN-1:0] rf_rdata;
  logic [4:0]  ex_addr, mem_addr, wb_addr, iss_rd, done_rd;
  logic        ex_wen, ex_load, mem_wen, mem_ok, wb_wen, lu_issue, lu_done, lu_kill;
  logic [XLEN-1:0] ex_data, mem_data, wb_data;
  logic [NRD*XLEN-1:0] rs_data_o;
  logic        stall_o, hang_o;
  logic [CW-1:0] stall_cnt_o;

  int nvec = 0;
  int nerr = 0;

  // Architectural model state
  bit busy_m[32];
  int cnt_m, run_m;
  bit hang_m;

  always #5 clk = ~clk;

  fwd_scoreboard #(.XLEN(XLEN), .NRD(NRD), .HANG_LIMIT(HL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs_addr_i(id_rs_addr), .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata),
    .ex_rd_addr_i(ex_addr), .ex_rd_wen_i(ex_wen), .ex_rd_data_i(ex_data), .ex_is_load_i(ex_load),
    .mem_rd_addr_i(mem_addr), .mem_rd_wen_i(mem_wen), .mem_rd_data_i(mem_data), .mem_data_ok_i(mem_ok),
    .wb_rd_addr_i(wb_addr), .wb_rd_wen_i(wb_wen), .wb_rd_data_i(wb_data),
    .lu_issue_i(lu_issue), .lu_issue_rd_i(iss_rd),
    .lu_done_i(lu_done), .lu_done_rd_i(done_rd), .lu_kill_i(lu_kill),
    .rs_data_o(rs_data_o), .stall_o(stall_o), .stall_cnt_o(stall_cnt_o), .hang_o(hang_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_stall(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (ex_wen && ex_addr == a) return ex_load;
    if (mem_wen && mem_addr == a) return !mem_ok;
    return busy_m[a] && !(lu_done && done_rd == a);
  endfunction

  function automatic logic [63:0] m_data(input logic [4:0] a, input logic [63:0] rf);
    if (a == 0) return 64'd0;
    if (ex_wen && ex_addr == a) return ex_data;
    if (mem_wen && mem_addr == a) return mem_data;
    if (busy_m[a] && lu_done && done_rd == a) return wb_data;
    if (wb_wen && wb_addr == a) return wb_data;
    return rf;
  endfunction

  task automatic idle();
    rst = 0; id_rs_addr = '0; rf_raddr_dummy();
    rf_rdata = '0;
    ex_addr = 0; ex_wen = 0; ex_data = 0; ex_load = 0;
    mem_addr = 0; mem_wen = 0; mem_data = 0; mem_ok = 1;
    wb_addr = 0; wb_wen = 0; wb_data = 0;
    lu_issue = 0; iss_rd = 0; lu_done = 0; done_rd = 0; lu_kill = 0;
  endtask

  task automatic rf_raddr_dummy();
  endtask

  task automatic model_edge(input bit st);
    if (rst) begin
      foreach (busy_m[i]) busy_m[i] = 0;
      cnt_m = 0; run_m = 0; hang_m = 0;
    end else begin
      if (lu_kill) foreach (busy_m[i]) busy_m[i] = 0;
      else begin
        if (lu_done && done_rd != 0) busy_m[done_rd] = 0;
        if (lu_issue && iss_rd != 0) busy_m[iss_rd] = 1;
      end
      if (st) begin
        if (cnt_m < CMAX) cnt_m++;
        run_m++;
        if (run_m >= HL) hang_m = 1;
      end else run_m = 0;
    end
  endtask

  // Check all outputs against the model, then clock one edge.
  task automatic cycle();
    bit es;
    #3;
    es = m_stall(id_rs_addr[4:0]) | m_stall(id_rs_addr[9:5]);
    chk("raddr", 64'(rf_raddr_o), 64'(id_rs_addr));
    chk("stall", 64'(stall_o), 64'(es));
    if (!es) begin
      chk("data0", rs_data_o[63:0],   m_data(id_rs_addr[4:0], rf_rdata[63:0]));
      chk("data1", rs_data_o[127:64], m_data(id_rs_addr[9:5], rf_rdata[127:64]));
    end
    chk("stall_cnt", 64'(stall_cnt_o), 64'(cnt_m));
    chk("hang", 64'(hang_o), 64'(hang_m));
    @(posedge clk);
    model_edge(es);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; cycle(); rst = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk); model_edge(1'b0); #1;
    rst = 0;
    #1;
    chk("rst_cnt", 64'(stall_cnt_o), 64'd0);
    chk("rst_hang", 64'(hang_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    cycle();

    // All stages write x5: EX wins
    id_rs_addr[4:0] = 5;
    ex_wen = 1; ex_addr = 5; ex_data = 64'hA;
    mem_wen = 1; mem_addr = 5; mem_data = 64'hB;
    wb_wen = 1; wb_addr = 5; wb_data = 64'hC;
    #1; chk("ex_prio", rs_data_o[63:0], 64'hA); chk("ex_prio_stall", 64'(stall_o), 64'd0);
    cycle();

    // x0 reads as zero
    idle(); id_rs_addr[4:0] = 0; ex_wen = 1; ex_addr = 0; ex_data = 64'hFF; rf_rdata[63:0] = 64'h1;
    #1; chk("x0_data", rs_data_o[63:0], 64'h0); chk("x0_stall", 64'(stall_o), 64'd0);
    cycle();

    // Load-use on port 1, then resolved from MEM
    idle(); id_rs_addr[9:5] = 7; ex_wen = 1; ex_addr = 7; ex_load = 1;
    #1; chk("load_use", 64'(stall_o), 64'd1);
    cycle();
    idle(); id_rs_addr[9:5] = 7; mem_wen = 1; mem_addr = 7; mem_ok = 1; mem_data = 64'h55;
    #1; chk("mem_fwd_stall", 64'(stall_o), 64'd0); chk("mem_fwd", rs_data_o[127:64], 64'h55);
    cycle();
    idle(); id_rs_addr[9:5] = 7; mem_wen = 1; mem_addr = 7; mem_ok = 0;
    #1; chk("mem_wait", 64'(stall_o), 64'd1);
    cycle();

    // Scoreboard: issue x9, stall 3 cycles, retire with WB forward
    idle(); do_reset();
    lu_issue = 1; iss_rd = 9; cycle();
    idle(); id_rs_addr[4:0] = 9;
    repeat (3) begin #1; chk("busy_stall", 64'(stall_o), 64'd1); cycle(); end
    lu_done = 1; done_rd = 9; wb_wen = 1; wb_addr = 9; wb_data = 64'h99;
    #1; chk("done_cnt", 64'(stall_cnt_o), 64'd3); chk("done_stall", 64'(stall_o), 64'd0);
    chk("done_fwd", rs_data_o[63:0], 64'h99);
    cycle();
    idle(); id_rs_addr[4:0] = 9; rf_rdata[63:0] = 64'h1234;
    #1; chk("busy_clr_stall", 64'(stall_o), 64'd0); chk("busy_clr_rf", rs_data_o[63:0], 64'h1234);
    cycle();

    // Hang detection with HANG_LIMIT=4
    idle(); do_reset();
    lu_issue = 1; iss_rd = 3; cycle();
    idle(); id_rs_addr[4:0] = 3;
    repeat (3) cycle();
    #1; chk("hang_pre", 64'(hang_o), 64'd0);
    cycle();
    #1; chk("hang_set", 64'(hang_o), 64'd1);
    lu_kill = 1; cycle(); lu_kill = 0;
    #1; chk("hang_sticky", 64'(hang_o), 64'd1); chk("kill_stall", 64'(stall_o), 64'd0);
    cycle();
    do_reset();
    #1; chk("hang_rst", 64'(hang_o), 64'd0); chk("cnt_rst", 64'(stall_cnt_o), 64'd0);

    // Same-register issue+done keeps busy; kill beats issue
    idle(); lu_issue = 1; iss_rd = 4; cycle();
    lu_done = 1; done_rd = 4; cycle();
    idle(); id_rs_addr[4:0] = 4;
    #1; chk("reissue_busy", 64'(stall_o), 64'd1);
    cycle();
    idle(); lu_kill = 1; lu_issue = 1; iss_rd = 6; cycle();
    idle(); id_rs_addr[4:0] = 6; id_rs_addr[9:5] = 4;
    #1; chk("kill_prio", 64'(stall_o), 64'd0);
    cycle();

    // Counter saturation
    do_reset();
    idle(); lu_issue = 1; iss_rd = 2; cycle();
    idle(); id_rs_addr[9:5] = 2;
    repeat (20) cycle();
    #1; chk("cnt_sat", 64'(stall_cnt_o), 64'(CMAX));

    // Randomized traffic
    do_reset();
    repeat (600) begin
      id_rs_addr[4:0] = 5'($urandom_range(0, 7));
      id_rs_addr[9:5] = 5'($urandom_range(0, 7));
      rf_rdata = {$urandom, $urandom, $urandom, $urandom};
      ex_addr  = 5'($urandom_range(0, 7)); ex_wen  = 1'($urandom); ex_load = ($urandom_range(0, 3) == 0);
      mem_addr = 5'($urandom_range(0, 7)); mem_wen = 1'($urandom); mem_ok  = ($urandom_range(0, 3) != 0);
      wb_addr  = 5'($urandom_range(0, 7)); wb_wen  = 1'($urandom);
      ex_data = {$urandom, $urandom}; mem_data = {$urandom, $urandom}; wb_data = {$urandom, $urandom};
      lu_issue = ($urandom_range(0, 3) == 0); iss_rd = 5'($urandom_range(0, 7));
      lu_done  = ($urandom_range(0, 3) == 0); done_rd = 5'($urandom_range(0, 7));
      if (lu_done) begin wb_wen = 1; wb_addr = done_rd; end
      lu_kill = ($urandom_range(0, 31) == 0);
      rst     = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
